// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: issue/result bundle between the EX-stage decoder and the mul/div unit
interface mul_div_unit_if #(parameter int DW = 32, parameter int OP_W = 3);
    logic            i_start;
    logic [OP_W-1:0] i_op;
    logic [DW-1:0]   i_a;
    logic [DW-1:0]   i_b;
    logic            o_busy;
    logic            o_done;
    logic [DW-1:0]   o_hi;
    logic [DW-1:0]   o_lo;
    modport master(output i_start, i_op, i_a, i_b, input o_busy, o_done, o_hi, o_lo);
    modport slave(input i_start, i_op, i_a, i_b, output o_busy, o_done, o_hi, o_lo);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO, constant ITER+1 latency
module mul_div_unit #(
    parameter int DW   = 32,
    parameter int OP_W = 3,
    parameter int ITER = 32
) (
    input logic          clk,
    input logic          rst,
    mul_div_unit_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam int CW = $clog2(ITER);
    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic [2*DW-1:0] r_acc;
    logic [DW-1:0]   r_den;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_hi;
    logic [DW-1:0]   r_lo;
    logic            r_is_div;
    logic            r_dz;
    logic            r_sign_q;
    logic            r_sign_r;
    logic            r_done;
    logic            w_signed;
    logic            w_div;
    logic [DW-1:0]   w_abs_a;
    logic [DW-1:0]   w_abs_b;
    logic [DW:0]     w_msum;
    logic            w_ge;
    logic [DW-1:0]   w_sub;
    logic [2*DW-1:0] w_mstep;
    logic [2*DW-1:0] w_dstep;
    logic [2*DW-1:0] w_prod;
    logic [DW-1:0]   w_quo;
    logic [DW-1:0]   w_rem;
    assign w_signed = ~bus.i_op[0];
    assign w_div    = bus.i_op[1];
    // 0x80000000 negates to itself, which reads correctly as the unsigned magnitude 2^31
    assign w_abs_a  = (w_signed && bus.i_a[DW-1]) ? -bus.i_a : bus.i_a;
    assign w_abs_b  = (w_signed && bus.i_b[DW-1]) ? -bus.i_b : bus.i_b;
    assign w_msum   = {1'b0, r_acc[2*DW-1:DW]} + (r_acc[0] ? {1'b0, r_den} : {(DW+1){1'b0}});
    assign w_mstep  = {w_msum, r_acc[DW-1:1]};
    // Shifted partial remainder is DW+1 bits wide; it is below 2*divisor so the difference fits DW
    assign w_ge     = r_acc[2*DW-1:DW-1] >= {1'b0, r_den};
    assign w_sub    = r_acc[2*DW-2:DW-1] - r_den;
    assign w_dstep  = {w_ge ? w_sub : r_acc[2*DW-2:DW-1], r_acc[DW-2:0], w_ge};
    assign w_prod   = r_sign_q ? -r_acc : r_acc;
    assign w_quo    = r_sign_q ? -r_acc[DW-1:0] : r_acc[DW-1:0];
    assign w_rem    = r_sign_r ? -r_acc[2*DW-1:DW] : r_acc[2*DW-1:DW];
    assign bus.o_busy = r_state != S_IDLE;
    assign bus.o_done = r_done;
    assign bus.o_hi   = r_hi;
    assign bus.o_lo   = r_lo;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_den    <= '0;
            r_a      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE && bus.i_start) begin
                if (!bus.i_op[2]) begin
                    r_state  <= S_RUN;
                    r_cnt    <= '0;
                    r_is_div <= w_div;
                    r_dz     <= bus.i_b == '0;
                    r_a      <= bus.i_a;
                    r_sign_q <= w_signed & (bus.i_a[DW-1] ^ bus.i_b[DW-1]);
                    r_sign_r <= w_signed & bus.i_a[DW-1];
                    r_acc    <= {{DW{1'b0}}, w_div ? w_abs_a : w_abs_b};
                    r_den    <= w_div ? w_abs_b : w_abs_a;
                end else if (bus.i_op == OP_W'(4)) begin
                    r_hi <= bus.i_a;
                end else if (bus.i_op == OP_W'(5)) begin
                    r_lo <= bus.i_a;
                end
            end else if (r_state == S_RUN) begin
                r_acc   <= r_is_div ? w_dstep : w_mstep;
                r_cnt   <= r_cnt + 1'b1;
                r_state <= (r_cnt == CW'(ITER - 1)) ? S_FIX : S_RUN;
            end else if (r_state == S_FIX) begin
                r_hi    <= !r_is_div ? w_prod[2*DW-1:DW] : r_dz ? r_a : w_rem;
                r_lo    <= !r_is_div ? w_prod[DW-1:0] : r_dz ? {DW{1'b1}} : w_quo;
                r_done  <= 1'b1;
                r_state <= S_IDLE;
            end
        end
    end
endmodule
